mult_seq_ctrl: RTL and testbench
================================

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request a multiply; sampled on each rising clk edge.
REQ-006 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 srcA  input  WIDTH  multiplicand; sampled with start.
REQ-008 srcB  input  WIDTH  multiplier; sampled with start.
REQ-009 busy  output  1  high while in CALC or FIX.
REQ-010 done  output  1  one-cycle pulse; high only in state DONE.
REQ-011 hi  output  WIDTH  upper half of the 2*WIDTH-bit product.
REQ-012 lo  output  WIDTH  lower half of the 2*WIDTH-bit product.

Function
REQ-013 State machine SHALL have exactly four states: IDLE, CALC, FIX and DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; accepted start moves the FSM to CALC on the next edge.
REQ-015 start in CALC or FIX SHALL be ignored: no state change and no operand capture.
REQ-016 On acceptance, srcA, srcB and is_signed SHALL be registered, and inputs are don't-care afterwards.
REQ-017 On acceptance with is_signed=1, operands SHALL be replaced by their magnitudes (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)), and neg = signA XOR signB SHALL be stored.
REQ-018 With is_signed=0, the operands SHALL be used as-is and neg SHALL be 0.
REQ-019 On acceptance, accumulator acc (WIDTH bits) SHALL clear, and the multiplier SHALL load into a shift register mq (WIDTH bits); the bit counter SHALL load WIDTH-1.
REQ-020 Each CALC cycle, sum SHALL be acc + (mq[0] ? |A| : 0), computed WIDTH+1 bits wide with no overflow loss.
REQ-021 Each CALC cycle, acc SHALL become sum[WIDTH:1] and mq SHALL become {sum[0], mq[WIDTH-1:1]}.
REQ-022 CALC SHALL last exactly WIDTH cycles; when the counter is 0, the next state SHALL be FIX, otherwise the counter decrements.
REQ-023 FIX SHALL last one cycle: {hi,lo} SHALL load {acc,mq} if neg=0, else the 2*WIDTH-bit two's-complement negation of {acc,mq}.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE unless start is high, in which case it goes to CALC.
REQ-025 Latency: start accepted at edge N SHALL give done=1 in cycle N+WIDTH+2 (WIDTH CALC cycles plus FIX plus DONE).
REQ-026 hi/lo SHALL change only at the FIX->DONE edge and hold until the next FIX; they are valid whenever done=1 and after it.
REQ-027 Operand of zero SHALL NOT shorten latency, because latency is data-independent.
REQ-028 busy and done SHALL never be high in the same cycle.

Reset
REQ-029 While rst=1, the FSM SHALL be IDLE, busy=0, done=0, hi=0, lo=0, and acc, mq, counter and neg SHALL be 0, with effect immediate (asynchronous).
REQ-030 Reset asserted mid-CALC or in FIX SHALL abort the operation, and no done SHALL be produced for it.
REQ-031 After rst deasserts, the first start SHALL be accepted on the first rising edge where it is high.

Verification (bench uses WIDTH=8)
REQ-032 Unsigned 0xFF*0xFF, is_signed=0 -> done exactly 10 cycles after the accept edge; hi=0xFE, lo=0x01.
REQ-033 Signed 0x80*0x7F (-128*127), is_signed=1 -> hi=0xC0, lo=0x80; signed 0x80*0x80 -> hi=0x40, lo=0x00; signed 0xFF*0xFF -> hi=0x00, lo=0x01.
REQ-034 Start re-pulsed with new operands during CALC and during FIX -> ignored; result equals the first operands; exactly one done pulse.
REQ-035 rst pulsed at the 4th CALC cycle -> outputs 0 at once, no done; then 0x03*0x05 unsigned -> hi=0x00, lo=0x0F.
REQ-036 Back-to-back: start held high through DONE -> second operation accepted in DONE, busy next cycle, second done 10 cycles later; 0x00*0xAB -> hi=0x00, lo=0x00 at the same latency.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier with a four-state control FSM.
// Signed operands are reduced to magnitudes on accept and the product sign
// is restored with a single two's-complement negation in the FIX state.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, nextState;

  logic             accept;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] negProd;

  // Operand magnitudes and the per-cycle add; the most negative value
  // wraps to itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    magA    = (is_signed && srcA[WIDTH-1]) ? (~srcA + 1'b1) : srcA;
    magB    = (is_signed && srcB[WIDTH-1]) ? (~srcB + 1'b1) : srcB;
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, aMag} : {(WIDTH+1){1'b0}});
    prod    = {acc, mq};
    negProd = ~prod + 1'b1;
  end

  // State register; reset drops straight back to IDLE and aborts any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) begin
          nextState = FIX;
        end
      end
      FIX: begin
        busy      = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          nextState = CALC;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift-add through CALC, sign-fix into hi/lo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aMag <= '0;
      acc  <= '0;
      mq   <= '0;
      cnt  <= '0;
      neg  <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else if (accept) begin
      aMag <= magA;
      mq   <= magB;
      acc  <= '0;
      cnt  <= CW'(WIDTH - 1);
      neg  <= is_signed & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
    end else begin
      case (state)
        CALC: begin
          acc <= sum[WIDTH:1];
          mq  <= {sum[0], mq[WIDTH-1:1]};
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          {hi, lo} <= neg ? negProd : prod;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl at WIDTH=8: stimulus pushes expected
// products, a negedge monitor pops and compares on every done pulse.
module tb_mult_seq_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             isSigned;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  typedef struct {
    logic [WIDTH-1:0] expHi;
    logic [WIDTH-1:0] expLo;
    int               acceptEdge;
    string            name;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  int   edgeCnt = 0;

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .is_signed(isSigned),
    .srcA(srcA),
    .srcB(srcB),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to measure accept-to-done latency.
  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpectedDone: got done=1 at edge %0d, expected no done", edgeCnt);
      end else begin
        cur = expQ.pop_front();
        checkOutput({cur.name, ".hi"}, 64'(hi), 64'(cur.expHi));
        checkOutput({cur.name, ".lo"}, 64'(lo), 64'(cur.expLo));
        // DONE occupies the cycle ending at accept edge + WIDTH + 2.
        checkOutput({cur.name, ".latency"}, 64'(edgeCnt - cur.acceptEdge), 64'(WIDTH + 1));
        checkOutput({cur.name, ".busyWithDone"}, 64'(busy), 64'(0));
      end
    end
  end

  task automatic pushExp(input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el, input string name);
    exp_t e;
    e.expHi      = eh;
    e.expLo      = el;
    e.acceptEdge = edgeCnt;
    e.name       = name;
    expQ.push_back(e);
  endtask

  // Drive one request at a negedge; the following rising edge accepts it.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic sgn, input logic [WIDTH-1:0] eh,
                               input logic [WIDTH-1:0] el, input string name,
                               input bit holdStart);
    @(negedge clk);
    srcA     = a;
    srcB     = b;
    isSigned = sgn;
    start    = 1'b1;
    @(posedge clk);
    #1;
    pushExp(eh, el, name);
    if (!holdStart) begin
      @(negedge clk);
      start = 1'b0;
      srcA  = $urandom_range(0, 255);
      srcB  = $urandom_range(0, 255);
    end
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic waitIdle(input string name);
    for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s.timeout: got %0d pending results, expected 0", name, expQ.size());
      expQ.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    isSigned = 1'b0;
    srcA     = '0;
    srcB     = '0;
    #1;
    checkOutput("reset.busy", 64'(busy), 64'(0));
    checkOutput("reset.done", 64'(done), 64'(0));
    checkOutput("reset.hi", 64'(hi), 64'(0));
    checkOutput("reset.lo", 64'(lo), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic unsigned and signed products.
    applyStimulus(8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01, "uFFxFF", 0);
    waitIdle("uFFxFF");
    applyStimulus(8'h80, 8'h7F, 1'b1, 8'hC0, 8'h80, "s80x7F", 0);
    waitIdle("s80x7F");
    applyStimulus(8'h80, 8'h80, 1'b1, 8'h40, 8'h00, "s80x80", 0);
    waitIdle("s80x80");
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'h00, 8'h01, "sFFxFF", 0);
    waitIdle("sFFxFF");
    applyStimulus(8'h80, 8'h7F, 1'b0, 8'h3F, 8'h80, "u80x7F", 0);
    waitIdle("u80x7F");
    applyStimulus(8'h85, 8'h07, 1'b1, 8'hFC, 8'hA3, "s85x07", 0);
    waitIdle("s85x07");

    // Start pulses during CALC and FIX must be ignored.
    applyStimulus(8'h12, 8'h34, 1'b0, 8'h03, 8'hA8, "ignore", 0);
    repeat (2) @(negedge clk);
    srcA = 8'h55; srcB = 8'h66; isSigned = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("ignore.busyInFix", 64'(busy), 64'(1));
    srcA = 8'h77; srcB = 8'h99; isSigned = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle("ignore");

    // Reset in the 4th CALC cycle aborts the run with no done.
    applyStimulus(8'h21, 8'h43, 1'b0, 8'h08, 8'hA3, "abort", 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(expQ.pop_back());
    checkOutput("abort.busy", 64'(busy), 64'(0));
    checkOutput("abort.done", 64'(done), 64'(0));
    checkOutput("abort.hi", 64'(hi), 64'(0));
    checkOutput("abort.lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    applyStimulus(8'h03, 8'h05, 1'b0, 8'h00, 8'h0F, "u03x05", 0);
    waitIdle("u03x05");

    // Back-to-back: start held through DONE starts the next op immediately.
    applyStimulus(8'h0F, 8'h11, 1'b0, 8'h00, 8'hFF, "b2bFirst", 1);
    repeat (10) @(negedge clk);
    checkOutput("b2b.doneInDone", 64'(done), 64'(1));
    srcA = 8'h00; srcB = 8'hAB; isSigned = 1'b0;
    @(posedge clk);
    #1;
    pushExp(8'h00, 8'h00, "b2bSecond");
    checkOutput("b2b.busyAfterAccept", 64'(busy), 64'(1));
    @(negedge clk);
    start = 1'b0;
    waitIdle("b2bSecond");

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
